div_iter32: RTL and testbench

- Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
- Consumes the team's 32-bit subtracting adder (fa32: inputs a, b, cin, sub; output s) as its per-iteration trial-subtract datapath.
- Produces quotient (LO) and remainder (HI) for the HI/LO write-back.
- Multi-cycle, with a start/cancel handshake toward the pipeline controller, which stalls while busy is high.

---
 rtl/div_iter32.sv | 134 +++++++++++++
 tb/tb_div_iter32.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_iter32.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per
// clock through a shared fa32 trial subtract, sign fixup applied on completion.

module fa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic [32:0] s
);
  logic [31:0] bx;
  logic [32:0] sum;

  // sub=1 computes a - b - cin; s[32] is then the borrow, otherwise the carry
  assign bx  = b ^ {32{sub}};
  assign sum = {1'b0, a} + {1'b0, bx} + {32'd0, cin ^ sub};
  assign s   = {sum[32] ^ sub, sum[31:0]};
endmodule

module div_iter32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  if (WIDTH != 32) begin : g_width_chk
    $error("div_iter32: WIDTH must be 32 to match the fa32 datapath");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_sh, quo_sh, rem_d, quo_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag = (signed_div && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign b_mag = (signed_div && divisor[WIDTH-1])  ? (~divisor  + WIDTH'(1)) : divisor;

  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};

  fa32 u_fa (
    .a   (rem_sh),
    .b   (dvs_q),
    .cin (1'b0),
    .sub (1'b1),
    .s   (trial)
  );

  // the bit shifted out of rem is the 33rd bit of the extended subtract
  assign ge    = rem_q[WIDTH-1] | ~trial[WIDTH];
  assign rem_d = ge ? trial[WIDTH-1:0] : rem_sh;
  assign quo_d = {quo_sh[WIDTH-1:1], ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !cancel) begin
            qneg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= signed_div & dividend[WIDTH-1];
            if (divisor == '0) begin
              dbz_q       <= 1'b1;
              quotient_q  <= '0;
              remainder_q <= dividend;
              state_q     <= S_DONE;
            end else begin
              dbz_q   <= 1'b0;
              rem_q   <= '0;
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              cnt_q   <= '0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cancel) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
              quotient_q  <= qneg_q ? (~quo_d + WIDTH'(1)) : quo_d;
              remainder_q <= rneg_q ? (~rem_d + WIDTH'(1)) : rem_d;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE) & ~cancel;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = dbz_q;
endmodule

// File: tb/tb_div_iter32.sv
// Directed bench for div_iter32: table of divide vectors plus hand-written
// cancel, start-while-busy and mid-operation reset sequences.

module tb_div_iter32;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start, signed_div, cancel;
  logic [31:0] dividend, divisor;
  logic        busy, result_valid, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  div_iter32 #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a, b, q, r;
    logic        z;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // called at a negedge (cycle 0); returns at the negedge of cycle 1
  task automatic go(input logic sd, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    step();
    cyc = 1;
    start = 1'b0; signed_div = ~sd; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_result(input int lat, input logic [31:0] eq, input logic [31:0] er,
                             input logic ez, input string nm);
    bit seen;
    int busy_gap;
    seen = 0;
    busy_gap = 0;
    while (!seen && cyc <= lat + 4) begin
      if (result_valid) begin
        seen = 1;
        chk({nm, " latency"}, 64'(cyc), 64'(lat));
        chk({nm, " quotient"}, 64'(quotient), 64'(eq));
        chk({nm, " remainder"}, 64'(remainder), 64'(er));
        chk({nm, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
      end else begin
        if (!busy) busy_gap++;
        step();
      end
    end
    if (!seen) chk({nm, " result_valid timeout"}, 64'(0), 64'(1));
    chk({nm, " busy held until result"}, 64'(busy_gap), 64'(0));
    step();
    chk({nm, " idle after result"}, 64'({busy, result_valid}), 64'(0));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;

    vt[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, "u100/7"};
    vt[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33, "s-7/2"};
    vt[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33, "s7/-2"};
    vt[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33, "s_ovf"};
    vt[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33, "u_8000/ffff"};
    vt[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33, "u_ffff/1"};
    vt[6] = '{1'b0, 32'h00001234,   32'd0,          32'd0,          32'h00001234,   1'b1, 1,  "dbz_u"};
    vt[7] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'd0,          32'hFFFFFFF9,   1'b1, 1,  "dbz_s"};
    vt[8] = '{1'b0, 32'd50,         32'd5,          32'd10,         32'd0,          1'b0, 33, "u50/5_clr"};

    repeat (2) @(negedge clk);
    chk("reset state", {busy, result_valid, div_by_zero, quotient, remainder[28:0]}, 64'(0));
    chk("reset remainder", 64'(remainder), 64'(0));
    resetn = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      go(vt[i].sd, vt[i].a, vt[i].b);
      wait_result(vt[i].lat, vt[i].q, vt[i].r, vt[i].z, vt[i].nm);
    end

    // cancel in cycle 10, then restart in cycle 12 (result due in cycle 45)
    go(1'b0, 32'd100, 32'd7);
    while (cyc < 10) step();
    cancel = 1'b1;
    chk("cancel rv low", 64'(result_valid), 64'(0));
    step();
    cancel = 1'b0;
    chk("cancel busy c11", 64'({busy, result_valid}), 64'(0));
    chk("cancel hold q", 64'(quotient), 64'(32'd10));
    chk("cancel hold r", 64'(remainder), 64'(32'd0));
    step();
    chk("cancel c12 idle", 64'({busy, result_valid}), 64'(0));
    go(1'b0, 32'd100, 32'd7);
    wait_result(33, 32'd14, 32'd2, 1'b0, "restart");

    // second start while running is dropped
    go(1'b0, 32'd100, 32'd7);
    while (cyc < 5) step();
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    step();
    start = 1'b0;
    wait_result(33, 32'd14, 32'd2, 1'b0, "start_busy");
    step();
    chk("no queued op", 64'({busy, result_valid}), 64'(0));

    // asynchronous reset mid-operation
    go(1'b0, 32'd1000, 32'd3);
    while (cyc < 20) step();
    #2 resetn = 1'b0;
    #1;
    chk("async reset busy/rv", 64'({busy, result_valid, div_by_zero}), 64'(0));
    chk("async reset q/r", {quotient, remainder}, 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("post reset idle", 64'({busy, result_valid}), 64'(0));
    go(1'b0, 32'd9, 32'd3);
    wait_result(33, 32'd3, 32'd0, 1'b0, "post_reset 9/3");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
